id_ex_stage_reg: RTL
====================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection. Captures decoded operands and
//  control from ID and drives EX. Its id_ex_registerA/B feed the forwarding unit.
//  Inserts a one-cycle bubble on load-use, honours flush (taken branch) and hold (memory busy).
// PARAMETERS
//  DATA_W   16  operand / immediate width
//  REG_W    4   register-address width (16 registers)
//  ALUOP_W  4   ALU opcode width
// PORTS
//  clk               in   1        rising-edge clock
//  reset             in   1        asynchronous, active-high
//  id_valid          in   1        ID holds a real instruction
//  id_regWrite       in   1        instruction writes rd
//  id_memRead        in   1        instruction is a load
//  id_memWrite       in   1        instruction is a store
//  id_useB           in   1        instruction reads registerB
//  id_aluOp          in   ALUOP_W  ALU opcode
//  id_registerA/B    in   REG_W    source register addresses
//  id_registerRD     in   REG_W    destination register address
//  id_dataA/B        in   DATA_W   register-file read data
//  id_imm            in   DATA_W   sign-extended immediate
//  flush             in   1        kill ID instruction (branch resolved taken in EX)
//  mem_hold          in   1        downstream busy: freeze ID/EX
//  id_ex_valid, id_ex_regWrite, id_ex_memRead, id_ex_memWrite   out 1      registered control
//  id_ex_aluOp       out  ALUOP_W  registered opcode
//  id_ex_registerA/B/RD out REG_W  registered addresses (to forwarding unit / EX/MEM)
//  id_ex_dataA/B, id_ex_imm out DATA_W  registered operands
//  stall             out  1        combinational: PC and IF/ID must hold this cycle
//  stall_count       out  16       only with ID_EX_STALL_COUNT_EN
// BEHAVIOUR
//  - Reset (async): every registered output 0 (bubble). stall_count 0.
//  - load_use = id_valid & id_ex_valid & id_ex_memRead & id_ex_regWrite &
//    (id_ex_registerRD==id_registerA | (id_useB & id_ex_registerRD==id_registerB)).
//  - Per-edge priority: flush > mem_hold > load_use > normal load.
//  - flush: control fields and valid <= 0. Data fields don't-care, held. stall = 0.
//  - mem_hold (no flush): all fields hold. stall = 1.
//  - load_use (no flush/hold): control/valid <= 0 (bubble). stall = 1 for exactly one cycle.
//    The bubble has memRead=0, so load_use drops next cycle. ID re-issues and EX forwards.
//  - normal: all fields <= id_* inputs. Latency 1 cycle ID->EX. stall = 0.
//  - stall = ~flush & (mem_hold | load_use). Purely combinational, no added latency.
//  - Invalid ID (id_valid=0) loads as bubble: all control 0 regardless of inputs.
//  - Reset mid-stall: outputs go to bubble immediately. stall = 0 while reset asserted.
// CONFIGURATION
//  ID_EX_STALL_COUNT_EN defined: 16-bit stall_count increments on each cycle a load-use bubble
//    is inserted (not hold/flush). Saturates at 16'hFFFF. Cleared only by reset.
//  Undefined: stall_count port and counter absent. Remaining behaviour identical.
// STRUCTURE
//  Package lapido_pkg: DATA_W, REG_W, ALUOP_W constants, id_ex_ctrl_t struct
//    {valid,regWrite,memRead,memWrite,aluOp}, constant CTRL_BUBBLE = '0.
//  Sub-module hazard_detect (combinational): computes load_use from ID and ID/EX fields.
//  Top-level file holds the register bank, priority mux and optional counter.
// TESTING
//  1 Reset: assert reset mid-stream -> all id_ex_* = 0, stall = 0 asynchronously.
//  2 Normal: ADD r3,r1,r2 in ID -> next edge id_ex_registerA=1, B=2, RD=3, regWrite=1, stall=0.
//  3 Load-use: LD r4 in EX, ID reads r4 as A -> stall=1 one cycle, bubble in ID/EX.
//    Next cycle stall=0 and dependent loads. With EN, stall_count 0->1.
//  4 useB gating: LD r4 in EX, ID reads r4 as B with id_useB=0 -> stall=0, no bubble.
//  5 Flush vs stall: load_use and flush same cycle -> stall=0, bubble loaded, count unchanged.
//  6 Hold: mem_hold=1 for 3 cycles -> id_ex_* frozen, stall=1 throughout. Resumes on release.

Source files
------------

// File: rtl/lapido_pkg.sv
// rtl/lapido_pkg.sv - shared widths and ID/EX control bundle for the lapido pipeline.
package lapido_pkg;

    localparam int DATA_W  = 16;
    localparam int REG_W   = 4;
    localparam int ALUOP_W = 4;

    typedef struct packed {
        logic               valid;
        logic               regWrite;
        logic               memRead;
        logic               memWrite;
        logic [ALUOP_W-1:0] aluOp;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// rtl/id_ex_stage_reg_if.sv - ID-side inputs and EX-side outputs of the ID/EX register.
// stall_count exists only when ID_EX_STALL_COUNT_EN is defined.
interface id_ex_stage_reg_if;
    import lapido_pkg::*;

    logic               id_valid;
    logic               id_regWrite;
    logic               id_memRead;
    logic               id_memWrite;
    logic               id_useB;
    logic [ALUOP_W-1:0] id_aluOp;
    logic [REG_W-1:0]   id_registerA;
    logic [REG_W-1:0]   id_registerB;
    logic [REG_W-1:0]   id_registerRD;
    logic [DATA_W-1:0]  id_dataA;
    logic [DATA_W-1:0]  id_dataB;
    logic [DATA_W-1:0]  id_imm;
    logic               flush;
    logic               mem_hold;

    logic               id_ex_valid;
    logic               id_ex_regWrite;
    logic               id_ex_memRead;
    logic               id_ex_memWrite;
    logic [ALUOP_W-1:0] id_ex_aluOp;
    logic [REG_W-1:0]   id_ex_registerA;
    logic [REG_W-1:0]   id_ex_registerB;
    logic [REG_W-1:0]   id_ex_registerRD;
    logic [DATA_W-1:0]  id_ex_dataA;
    logic [DATA_W-1:0]  id_ex_dataB;
    logic [DATA_W-1:0]  id_ex_imm;
    logic               stall;
`ifdef ID_EX_STALL_COUNT_EN
    logic [15:0]        stall_count;
`endif

    modport master (
        output id_valid, id_regWrite, id_memRead, id_memWrite, id_useB, id_aluOp,
               id_registerA, id_registerB, id_registerRD, id_dataA, id_dataB, id_imm,
               flush, mem_hold,
        input  id_ex_valid, id_ex_regWrite, id_ex_memRead, id_ex_memWrite, id_ex_aluOp,
               id_ex_registerA, id_ex_registerB, id_ex_registerRD,
               id_ex_dataA, id_ex_dataB, id_ex_imm,
               stall
`ifdef ID_EX_STALL_COUNT_EN
        , input stall_count
`endif
    );

    modport slave (
        input  id_valid, id_regWrite, id_memRead, id_memWrite, id_useB, id_aluOp,
               id_registerA, id_registerB, id_registerRD, id_dataA, id_dataB, id_imm,
               flush, mem_hold,
        output id_ex_valid, id_ex_regWrite, id_ex_memRead, id_ex_memWrite, id_ex_aluOp,
               id_ex_registerA, id_ex_registerB, id_ex_registerRD,
               id_ex_dataA, id_ex_dataB, id_ex_imm,
               stall
`ifdef ID_EX_STALL_COUNT_EN
        , output stall_count
`endif
    );

endinterface

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// rtl/id_ex_stage_reg_hazard_detect.sv - combinational load-use detection between ID and EX.
module hazard_detect
    import lapido_pkg::*;
(
    input  logic             id_valid,
    input  logic             id_useB,
    input  logic [REG_W-1:0] id_registerA,
    input  logic [REG_W-1:0] id_registerB,
    input  logic             ex_valid,
    input  logic             ex_memRead,
    input  logic             ex_regWrite,
    input  logic [REG_W-1:0] ex_registerRD,
    output logic             load_use
);

    logic match_a;
    logic match_b;

    assign match_a  = (ex_registerRD == id_registerA);
    // registerB only counts when the ID instruction actually reads it
    assign match_b  = id_useB & (ex_registerRD == id_registerB);
    assign load_use = id_valid & ex_valid & ex_memRead & ex_regWrite & (match_a | match_b);

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use bubble, flush and hold.
// Optional stall_count (load-use bubbles, saturating) enabled by ID_EX_STALL_COUNT_EN.
module id_ex_stage_reg
    import lapido_pkg::*;
(
    input logic              clk,
    input logic              reset,
    id_ex_stage_reg_if.slave bus
);

    id_ex_ctrl_t       ctrl_q;
    id_ex_ctrl_t       id_ctrl;
    logic [REG_W-1:0]  reg_a_q;
    logic [REG_W-1:0]  reg_b_q;
    logic [REG_W-1:0]  reg_rd_q;
    logic [DATA_W-1:0] data_a_q;
    logic [DATA_W-1:0] data_b_q;
    logic [DATA_W-1:0] imm_q;
    logic              load_use;

    hazard_detect u_hazard_detect (
        .id_valid      (bus.id_valid),
        .id_useB       (bus.id_useB),
        .id_registerA  (bus.id_registerA),
        .id_registerB  (bus.id_registerB),
        .ex_valid      (ctrl_q.valid),
        .ex_memRead    (ctrl_q.memRead),
        .ex_regWrite   (ctrl_q.regWrite),
        .ex_registerRD (reg_rd_q),
        .load_use      (load_use)
    );

    // An invalid ID slot always enters EX as a bubble, whatever its control bits say
    always_comb begin
        id_ctrl = CTRL_BUBBLE;
        if (bus.id_valid) begin
            id_ctrl.valid    = 1'b1;
            id_ctrl.regWrite = bus.id_regWrite;
            id_ctrl.memRead  = bus.id_memRead;
            id_ctrl.memWrite = bus.id_memWrite;
            id_ctrl.aluOp    = bus.id_aluOp;
        end
    end

    // Priority: flush > mem_hold > load_use > normal load; data only moves on a normal load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= CTRL_BUBBLE;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            reg_rd_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            imm_q    <= '0;
        end else if (bus.flush) begin
            ctrl_q <= CTRL_BUBBLE;
        end else if (!bus.mem_hold) begin
            if (load_use) begin
                ctrl_q <= CTRL_BUBBLE;
            end else begin
                ctrl_q   <= id_ctrl;
                reg_a_q  <= bus.id_registerA;
                reg_b_q  <= bus.id_registerB;
                reg_rd_q <= bus.id_registerRD;
                data_a_q <= bus.id_dataA;
                data_b_q <= bus.id_dataB;
                imm_q    <= bus.id_imm;
            end
        end
    end

    assign bus.stall = ~reset & ~bus.flush & (bus.mem_hold | load_use);

    assign bus.id_ex_valid      = ctrl_q.valid;
    assign bus.id_ex_regWrite   = ctrl_q.regWrite;
    assign bus.id_ex_memRead    = ctrl_q.memRead;
    assign bus.id_ex_memWrite   = ctrl_q.memWrite;
    assign bus.id_ex_aluOp      = ctrl_q.aluOp;
    assign bus.id_ex_registerA  = reg_a_q;
    assign bus.id_ex_registerB  = reg_b_q;
    assign bus.id_ex_registerRD = reg_rd_q;
    assign bus.id_ex_dataA      = data_a_q;
    assign bus.id_ex_dataB      = data_b_q;
    assign bus.id_ex_imm        = imm_q;

`ifdef ID_EX_STALL_COUNT_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (!bus.flush && !bus.mem_hold && load_use && stall_count_q != 16'hFFFF) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign bus.stall_count = stall_count_q;
`endif

endmodule
